bus_capture_wr: RTL and testbench
=================================

BUS_CAPTURE_WR -- requirements
Module: bus_capture_wr

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 16-bit words in the capture RAM (power of 2, 2..65536).
REQ-002 SHALL have ports as follows; clock is i_Bus_Clk and reset is i_Bus_Rst_L, with one clock and an asynchronous, active-low reset.
- i_Bus_Clk  in  1  sole clock
- i_Bus_Rst_L  in  1  async active-low reset
- i_Bus_CS  in  1  register-space select
- i_Bus_Wr_Rd_n  in  1  1=write, 0=read
- i_Bus_Addr8  in  16  byte address; bits[2:1] select register
- i_Bus_Wr_Data  in  16  bus write data
- o_Bus_Rd_Data  out  16  register read data
- o_Bus_Rd_DV  out  1  read data valid
- i_Trig  in  1  capture trigger, level sampled
- i_Smp_DV  in  1  sample valid strobe
- i_Smp_Data  in  16  sample word
- o_Wr_Addr  out  $clog2(DEPTH)  capture RAM write address
- o_Wr_DV  out  1  capture RAM write strobe
- o_Wr_Data  out  16  capture RAM write data
- o_Done_Irq  out  1  one-cycle pulse on capture completion

Function
REQ-003 SHALL decode register offsets from i_Bus_Addr8[2:1]: 0=CTRL, 1=LENGTH, 2=STATUS, 3=COUNT.
REQ-004 SHALL update CTRL as write-only strobes: bit0 ARM, bit1 ABORT; CTRL SHALL read back 0x0000.
REQ-005 SHALL hold LENGTH as a 16-bit R/W register; a write of 0 or of a value > DEPTH SHALL store DEPTH; writes SHALL be ignored while state != IDLE and != DONE.
REQ-006 SHALL return STATUS = {12'b0, state[1:0], done, busy}, where busy=1 in ARMED or CAPTURE and done=1 in DONE.
REQ-007 SHALL return COUNT = number of words written in the current or last capture, zero-extended.
REQ-008 SHALL register bus reads: o_Bus_Rd_DV pulses 1 cycle after a cycle with i_Bus_CS=1 and i_Bus_Wr_Rd_n=0, with data valid on that same cycle; otherwise o_Bus_Rd_DV=0.
REQ-009 SHALL implement states IDLE(0), ARMED(1), CAPTURE(2), DONE(3).
REQ-010 SHALL, on ARM in IDLE or DONE, clear COUNT and enter ARMED; ARM in ARMED or CAPTURE SHALL be ignored.
REQ-011 SHALL, in ARMED, move to CAPTURE on the first cycle with i_Trig=1; if i_Smp_DV=1 in that same cycle, that sample SHALL be written to address 0.
REQ-012 SHALL, in CAPTURE (and on the trigger cycle), register each sample: o_Wr_DV=1, o_Wr_Data=i_Smp_Data, and o_Wr_Addr=COUNT[low bits], one cycle after i_Smp_DV; COUNT SHALL then increment.
REQ-013 SHALL enter DONE when COUNT reaches LENGTH, pulse o_Done_Irq for exactly one cycle, and ignore further samples; addresses SHALL never wrap.
REQ-014 SHALL, on ABORT, return to IDLE from any state in the next cycle, preserving COUNT and dropping no write already registered; ABORT and ARM in the same write SHALL resolve to ABORT.
REQ-015 SHALL keep o_Wr_DV=0 in IDLE, ARMED and DONE except for the final registered write in flight.

Reset
REQ-016 SHALL, while i_Bus_Rst_L=0, asynchronously force state=IDLE, LENGTH=DEPTH, COUNT=0, and all outputs to 0.
REQ-017 SHALL, on reset mid-capture, abandon the capture with no further o_Wr_DV pulses after deassertion.

Structure
REQ-018 SHALL place register offsets, CTRL bit positions and the state encoding in shared package bus_capture_pkg.
REQ-019 SHALL be a single module with no sub-module; o_Wr_* SHALL connect directly to the write port of the bus-readable dual-port RAM.

Verification
REQ-020 Set LENGTH=4, ARM, raise i_Trig, send samples 0xA0..0xA5 -> writes 0xA0..0xA3 to addresses 0..3, one o_Done_Irq, STATUS=0x000E, COUNT=4.
REQ-021 Write LENGTH=0, then LENGTH=0x0300 with DEPTH=256 -> LENGTH reads 0x0100 both times.
REQ-022 ARM with i_Trig and i_Smp_DV=1 (data 0x1234) in the same cycle -> address 0 receives 0x1234.
REQ-023 ABORT after 2 of 8 samples -> STATUS=0x0000, COUNT=2, no further o_Wr_DV, no o_Done_Irq.
REQ-024 Assert i_Bus_Rst_L=0 mid-capture -> outputs 0 immediately; after release LENGTH=DEPTH and STATUS=0.
REQ-025 Write CTRL=0x0003 in IDLE -> state remains IDLE; ARM while ARMED -> no change.

Source files
------------

// File: rtl/bus_capture_pkg.sv
// Shared register map, control bit positions and FSM encoding for the
// bus-controlled sample capture writer.
package bus_capture_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LENGTH = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int CTRL_ARM_BIT   = 0;
  localparam int CTRL_ABORT_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // STATUS layout: {12'b0, state, done, busy}
  function automatic logic [15:0] status_word(input state_t st);
    logic busy;
    logic done;
    busy = (st == ST_ARMED) || (st == ST_CAPTURE);
    done = (st == ST_DONE);
    status_word = {12'h000, st, done, busy};
  endfunction

endpackage

// File: rtl/bus_capture_wr.sv
// Bus-programmed capture engine: after ARM and trigger, streams valid samples
// into a capture RAM write port until LENGTH words are stored.
module bus_capture_wr
  import bus_capture_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     i_Bus_Clk,
  input  logic                     i_Bus_Rst_L,
  input  logic                     i_Bus_CS,
  input  logic                     i_Bus_Wr_Rd_n,
  input  logic [15:0]              i_Bus_Addr8,
  input  logic [15:0]              i_Bus_Wr_Data,
  output logic [15:0]              o_Bus_Rd_Data,
  output logic                     o_Bus_Rd_DV,
  input  logic                     i_Trig,
  input  logic                     i_Smp_DV,
  input  logic [15:0]              i_Smp_Data,
  output logic [$clog2(DEPTH)-1:0] o_Wr_Addr,
  output logic                     o_Wr_DV,
  output logic [15:0]              o_Wr_Data,
  output logic                     o_Done_Irq
);

  localparam int AW = $clog2(DEPTH);
  // One extra bit so COUNT/LENGTH can hold DEPTH itself.
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   length_q, length_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]     wr_data_q, wr_data_d;
  logic            wr_dv_q, wr_dv_d;
  logic            done_irq_q, done_irq_d;
  logic [15:0]     rd_data_q, rd_data_d;
  logic            rd_dv_q, rd_dv_d;

  logic [1:0] reg_sel_s;
  logic       bus_wr_s;
  logic       bus_rd_s;
  logic       ctrl_wr_s;
  logic       abort_s;
  logic       arm_s;
  logic       accept_s;
  logic       last_s;
  logic       len_idle_s;

  assign reg_sel_s = i_Bus_Addr8[2:1];
  assign bus_wr_s  = i_Bus_CS & i_Bus_Wr_Rd_n;
  assign bus_rd_s  = i_Bus_CS & ~i_Bus_Wr_Rd_n;
  assign ctrl_wr_s = bus_wr_s & (reg_sel_s == REG_CTRL);
  // ABORT outranks ARM when both strobes arrive in one write.
  assign abort_s   = ctrl_wr_s & i_Bus_Wr_Data[CTRL_ABORT_BIT];
  assign arm_s     = ctrl_wr_s & i_Bus_Wr_Data[CTRL_ARM_BIT] & ~abort_s;
  assign accept_s  = ~abort_s & i_Smp_DV &
                     ((state_q == ST_CAPTURE) || ((state_q == ST_ARMED) && i_Trig));
  assign last_s    = accept_s && ((count_q + CW'(1)) == length_q);
  assign len_idle_s = (state_q == ST_IDLE) || (state_q == ST_DONE);

  // State register
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_s) state_d = ST_ARMED;
          else       state_d = state_q;
        end
        ST_ARMED: begin
          if (i_Trig) state_d = last_s ? ST_DONE : ST_CAPTURE;
          else        state_d = ST_ARMED;
        end
        ST_CAPTURE: begin
          if (last_s) state_d = ST_DONE;
          else        state_d = ST_CAPTURE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    count_d    = count_q;
    length_d   = length_q;
    wr_dv_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_irq_d = last_s;
    rd_dv_d    = bus_rd_s;
    rd_data_d  = 16'h0000;

    if (accept_s) begin
      wr_dv_d   = 1'b1;
      wr_addr_d = count_q[AW-1:0];
      wr_data_d = i_Smp_Data;
      count_d   = count_q + CW'(1);
    end else if (arm_s && len_idle_s) begin
      count_d = {CW{1'b0}};
    end else begin
      count_d = count_q;
    end

    if (bus_wr_s && (reg_sel_s == REG_LENGTH) && len_idle_s) begin
      if ((i_Bus_Wr_Data == 16'h0000) || ({1'b0, i_Bus_Wr_Data} > 17'(DEPTH))) begin
        length_d = DEPTH_C;
      end else begin
        length_d = CW'(i_Bus_Wr_Data);
      end
    end else begin
      length_d = length_q;
    end

    if (bus_rd_s) begin
      case (reg_sel_s)
        REG_CTRL:   rd_data_d = 16'h0000;
        REG_LENGTH: rd_data_d = 16'(length_q);
        REG_STATUS: rd_data_d = status_word(state_q);
        REG_COUNT:  rd_data_d = 16'(count_q);
        default:    rd_data_d = 16'h0000;
      endcase
    end else begin
      rd_data_d = 16'h0000;
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      count_q    <= {CW{1'b0}};
      length_q   <= DEPTH_C;
      wr_dv_q    <= 1'b0;
      wr_addr_q  <= {AW{1'b0}};
      wr_data_q  <= 16'h0000;
      done_irq_q <= 1'b0;
      rd_dv_q    <= 1'b0;
      rd_data_q  <= 16'h0000;
    end else begin
      count_q    <= count_d;
      length_q   <= length_d;
      wr_dv_q    <= wr_dv_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_irq_q <= done_irq_d;
      rd_dv_q    <= rd_dv_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign o_Wr_DV       = wr_dv_q;
  assign o_Wr_Addr     = wr_addr_q;
  assign o_Wr_Data     = wr_data_q;
  assign o_Done_Irq    = done_irq_q;
  assign o_Bus_Rd_DV   = rd_dv_q;
  assign o_Bus_Rd_Data = rd_data_q;

endmodule

// File: tb/tb_bus_capture_wr.sv
// Directed bench for bus_capture_wr: register-access vector table followed by
// hand-written capture, abort and reset sequences.
module tb_bus_capture_wr;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rd_data;
  logic        rd_dv;
  logic        trig = 1'b0;
  logic        smp_dv = 1'b0;
  logic [15:0] smp_data = 16'h0000;
  logic [7:0]  wr_addr;
  logic        wr_dv;
  logic [15:0] wr_data_o;
  logic        done_irq;

  int total = 0;
  int bad = 0;

  logic [7:0]  mon_addr[$];
  logic [15:0] mon_data[$];
  int          irq_cnt = 0;

  bus_capture_wr #(.DEPTH(DEPTH)) dut (
    .i_Bus_Clk     (clk),
    .i_Bus_Rst_L   (rst_n),
    .i_Bus_CS      (cs),
    .i_Bus_Wr_Rd_n (wr),
    .i_Bus_Addr8   (addr),
    .i_Bus_Wr_Data (wdata),
    .o_Bus_Rd_Data (rd_data),
    .o_Bus_Rd_DV   (rd_dv),
    .i_Trig        (trig),
    .i_Smp_DV      (smp_dv),
    .i_Smp_Data    (smp_data),
    .o_Wr_Addr     (wr_addr),
    .o_Wr_DV       (wr_dv),
    .o_Wr_Data     (wr_data_o),
    .o_Done_Irq    (done_irq)
  );

  always #5 clk = ~clk;

  // RAM write / interrupt monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_dv) begin
      mon_addr.push_back(wr_addr);
      mon_data.push_back(wr_data_o);
    end
    if (done_irq) irq_cnt <= irq_cnt + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] sel, input logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = 16'h0100 | {13'h0000, sel, 1'b0}; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    check("no_rd_dv_on_write", {31'h0, rd_dv}, 32'h0);
  endtask

  task automatic bus_read(input logic [1:0] sel, output logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b0; addr = 16'h0100 | {13'h0000, sel, 1'b0};
    @(negedge clk);
    cs = 1'b0;
    check("rd_dv", {31'h0, rd_dv}, 32'h1);
    d = rd_data;
  endtask

  task automatic read_check(input string nm, input logic [1:0] sel, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(sel, d);
    check(nm, {16'h0, d}, {16'h0, exp});
  endtask

  typedef struct {
    logic        is_wr;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [15:0] exp;
  } bus_vec_t;

  bus_vec_t vecs[18];

  initial begin
    int base;
    int irq_base;
    logic [15:0] d;

    vecs[0]  = '{1'b0, 2'd1, 16'h0000, 16'h0100};
    vecs[1]  = '{1'b0, 2'd2, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 2'd3, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 2'd0, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 2'd1, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 2'd1, 16'h0000, 16'h0100};
    vecs[6]  = '{1'b1, 2'd1, 16'h0300, 16'h0000};
    vecs[7]  = '{1'b0, 2'd1, 16'h0000, 16'h0100};
    vecs[8]  = '{1'b1, 2'd1, 16'h0101, 16'h0000};
    vecs[9]  = '{1'b0, 2'd1, 16'h0000, 16'h0100};
    vecs[10] = '{1'b1, 2'd1, 16'h0005, 16'h0000};
    vecs[11] = '{1'b0, 2'd1, 16'h0000, 16'h0005};
    vecs[12] = '{1'b1, 2'd1, 16'h0001, 16'h0000};
    vecs[13] = '{1'b0, 2'd1, 16'h0000, 16'h0001};
    vecs[14] = '{1'b1, 2'd1, 16'h0100, 16'h0000};
    vecs[15] = '{1'b0, 2'd1, 16'h0000, 16'h0100};
    vecs[16] = '{1'b1, 2'd0, 16'h0000, 16'h0000};
    vecs[17] = '{1'b0, 2'd2, 16'h0000, 16'h0000};

    // Reset state
    #12;
    check("rst_wr_dv", {31'h0, wr_dv}, 32'h0);
    check("rst_rd_dv", {31'h0, rd_dv}, 32'h0);
    check("rst_irq", {31'h0, done_irq}, 32'h0);
    check("rst_rd_data", {16'h0, rd_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Register-access vector table
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].sel, vecs[i].data);
      end else begin
        bus_read(vecs[i].sel, d);
        check($sformatf("vec%0d_read", i), {16'h0, d}, {16'h0, vecs[i].exp});
      end
    end

    // ABORT+ARM resolves to ABORT; ARM ignored while busy; LENGTH locked while busy
    bus_write(2'd0, 16'h0003);
    read_check("armabort_status", 2'd2, 16'h0000);
    bus_write(2'd0, 16'h0001);
    read_check("armed_status", 2'd2, 16'h0005);
    bus_write(2'd1, 16'h0003);
    read_check("len_locked", 2'd1, 16'h0100);
    bus_write(2'd0, 16'h0001);
    read_check("rearm_status", 2'd2, 16'h0005);
    @(negedge clk);
    trig = 1'b1; smp_dv = 1'b1; smp_data = 16'h0055;
    @(negedge clk);
    smp_dv = 1'b0; trig = 1'b0;
    read_check("cap_status", 2'd2, 16'h0009);
    bus_write(2'd0, 16'h0001);
    read_check("arm_in_cap_count", 2'd3, 16'h0001);
    read_check("arm_in_cap_status", 2'd2, 16'h0009);
    bus_write(2'd0, 16'h0002);
    read_check("abort_status", 2'd2, 16'h0000);
    read_check("abort_count", 2'd3, 16'h0001);

    // Basic capture of LENGTH=4 with surplus samples
    bus_write(2'd1, 16'h0004);
    bus_write(2'd0, 16'h0001);
    base = mon_addr.size();
    irq_base = irq_cnt;
    @(negedge clk);
    trig = 1'b1;
    for (int i = 0; i < 6; i++) begin
      smp_dv = 1'b1; smp_data = 16'h00A0 + 16'(i);
      @(negedge clk);
    end
    smp_dv = 1'b0; trig = 1'b0;
    repeat (3) @(negedge clk);
    check("cap4_nwrites", mon_addr.size() - base, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < mon_addr.size()) begin
        check($sformatf("cap4_addr%0d", i), {24'h0, mon_addr[base + i]}, i);
        check($sformatf("cap4_data%0d", i), {16'h0, mon_data[base + i]}, 32'h00A0 + i);
      end
    end
    check("cap4_irq", irq_cnt - irq_base, 32'd1);
    read_check("cap4_status", 2'd2, 16'h000E);
    read_check("cap4_count", 2'd3, 16'h0004);

    // Trigger and sample in the same cycle, re-armed from DONE
    bus_write(2'd1, 16'h0002);
    bus_write(2'd0, 16'h0001);
    read_check("rearm_count_clr", 2'd3, 16'h0000);
    base = mon_addr.size();
    irq_base = irq_cnt;
    @(negedge clk);
    trig = 1'b1; smp_dv = 1'b1; smp_data = 16'h1234;
    @(negedge clk);
    trig = 1'b0; smp_data = 16'h5678;
    @(negedge clk);
    smp_dv = 1'b0;
    repeat (2) @(negedge clk);
    check("trig_nwrites", mon_addr.size() - base, 32'd2);
    if (base + 1 < mon_addr.size()) begin
      check("trig_addr0", {24'h0, mon_addr[base]}, 32'h0);
      check("trig_data0", {16'h0, mon_data[base]}, 32'h1234);
      check("trig_addr1", {24'h0, mon_addr[base + 1]}, 32'h1);
      check("trig_data1", {16'h0, mon_data[base + 1]}, 32'h5678);
    end
    check("trig_irq", irq_cnt - irq_base, 32'd1);

    // ABORT after 2 of 8 samples
    bus_write(2'd1, 16'h0008);
    bus_write(2'd0, 16'h0001);
    base = mon_addr.size();
    irq_base = irq_cnt;
    @(negedge clk);
    trig = 1'b1;
    for (int i = 0; i < 2; i++) begin
      smp_dv = 1'b1; smp_data = 16'h00B0 + 16'(i);
      @(negedge clk);
    end
    smp_dv = 1'b0;
    bus_write(2'd0, 16'h0002);
    for (int i = 0; i < 3; i++) begin
      smp_dv = 1'b1; smp_data = 16'h00C0 + 16'(i);
      @(negedge clk);
    end
    smp_dv = 1'b0; trig = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_nwrites", mon_addr.size() - base, 32'd2);
    check("abort_irq", irq_cnt - irq_base, 32'd0);
    read_check("abort2_status", 2'd2, 16'h0000);
    read_check("abort2_count", 2'd3, 16'h0002);

    // Reset in the middle of a capture
    bus_write(2'd1, 16'h0010);
    bus_write(2'd0, 16'h0001);
    @(negedge clk);
    trig = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp_dv = 1'b1; smp_data = 16'h00D0 + 16'(i);
      @(negedge clk);
    end
    check("pre_rst_wr_dv", {31'h0, wr_dv}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wr_dv", {31'h0, wr_dv}, 32'h0);
    check("rst_mid_wr_data", {16'h0, wr_data_o}, 32'h0);
    check("rst_mid_wr_addr", {24'h0, wr_addr}, 32'h0);
    base = mon_addr.size();
    irq_base = irq_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    smp_dv = 1'b0; trig = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_nwrites", mon_addr.size() - base, 32'd0);
    check("post_rst_irq", irq_cnt - irq_base, 32'd0);
    read_check("post_rst_length", 2'd1, 16'h0100);
    read_check("post_rst_status", 2'd2, 16'h0000);
    read_check("post_rst_count", 2'd3, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
